// File: rtl/apb_reg_bridge.sv
// rtl/apb_reg_bridge.sv - APB slave front-end for the timer register file
// Terminates APB transfers, drives the internal register bus and muxes read data.
module apb_reg_bridge #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [12:0] paddr,
  input  logic [31:0] pwdata,
  output logic        pready,
  output logic        pslverr,
  output logic [31:0] prdata,
  output logic [12:0] addr,
  output logic [31:0] wr_data,
  output logic        wr_en,
  output logic        rd_en,
  input  logic [31:0] tcr_rd,
  input  logic [31:0] tdr0_rd,
  input  logic [31:0] tdr1_rd,
  input  logic [31:0] tcmp0_rd,
  input  logic [31:0] tcmp1_rd,
  input  logic [31:0] tier_rd,
  input  logic [31:0] tisr_rd,
  input  logic [31:0] thcsr_rd
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [2:0] WAIT_N = 3'(WAIT_CYCLES);

  state_t      state;
  logic [2:0]  cnt;
  logic        wr_lat;
  logic        err;
  logic [31:0] rd_mux;

  assign err = (addr[1:0] != 2'b00) || (addr > 13'h001C);

  // Completion needs psel/penable still asserted so an abort never strobes.
  assign pready  = (state == ACCESS) && (cnt == WAIT_N) && psel && penable;
  assign pslverr = pready && err;
  assign wr_en   = pready && !err && wr_lat;
  assign rd_en   = pready && !err && !wr_lat;

  always_comb begin
    rd_mux = '0;
    case (addr[4:2])
      3'd0: rd_mux = tcr_rd;
      3'd1: rd_mux = tdr0_rd;
      3'd2: rd_mux = tdr1_rd;
      3'd3: rd_mux = tcmp0_rd;
      3'd4: rd_mux = tcmp1_rd;
      3'd5: rd_mux = tier_rd;
      3'd6: rd_mux = tisr_rd;
      3'd7: rd_mux = thcsr_rd;
      default: rd_mux = '0;
    endcase
  end

  assign prdata = rd_en ? rd_mux : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      addr    <= 13'h0;
      wr_data <= 32'h0;
      wr_lat  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (psel && !penable) begin
            addr    <= paddr;
            wr_data <= pwdata;
            wr_lat  <= pwrite;
            cnt     <= 3'd0;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (!psel) begin
            cnt   <= 3'd0;
            state <= IDLE;
          end else if (pready) begin
            state <= IDLE;
          end else if (penable) begin
            cnt <= cnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_reg_bridge.sv
// tb/tb_apb_reg_bridge.sv - directed self-checking bench for apb_reg_bridge
// Two instances (0 and 3 wait states) share one APB stimulus bus.
module tb_apb_reg_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [12:0] paddr;
  logic [31:0] pwdata;

  logic        pready0, pslverr0, wr_en0, rd_en0;
  logic [31:0] prdata0, wr_data0;
  logic [12:0] addr0;
  logic        pready3, pslverr3, wr_en3, rd_en3;
  logic [31:0] prdata3, wr_data3;
  logic [12:0] addr3;

  logic [31:0] regs0 [8];
  logic [31:0] regs3 [8];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int wr_cnt0 = 0, rd_cnt0 = 0, wr_cnt3 = 0, rd_cnt3 = 0;
  int wr_t_prev = 0, wr_t_last = 0;

  logic        sel3 = 1'b0;
  logic        s_pready, s_pslverr;
  logic [31:0] s_prdata, s_wdata;
  logic [12:0] s_addr;

  logic [31:0] obs_prdata, obs_wdata;
  logic [12:0] obs_addr;
  logic        obs_err, pre_nz, stray_hit;
  int          obs_len, obs_wr, obs_rd;

  always #5 clk = ~clk;

  apb_reg_bridge #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready0), .pslverr(pslverr0),
    .prdata(prdata0), .addr(addr0), .wr_data(wr_data0), .wr_en(wr_en0), .rd_en(rd_en0),
    .tcr_rd(regs0[0]), .tdr0_rd(regs0[1]), .tdr1_rd(regs0[2]), .tcmp0_rd(regs0[3]),
    .tcmp1_rd(regs0[4]), .tier_rd(regs0[5]), .tisr_rd(regs0[6]), .thcsr_rd(regs0[7])
  );

  apb_reg_bridge #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready3), .pslverr(pslverr3),
    .prdata(prdata3), .addr(addr3), .wr_data(wr_data3), .wr_en(wr_en3), .rd_en(rd_en3),
    .tcr_rd(regs3[0]), .tdr0_rd(regs3[1]), .tdr1_rd(regs3[2]), .tcmp0_rd(regs3[3]),
    .tcmp1_rd(regs3[4]), .tier_rd(regs3[5]), .tisr_rd(regs3[6]), .thcsr_rd(regs3[7])
  );

  assign s_pready  = sel3 ? pready3  : pready0;
  assign s_pslverr = sel3 ? pslverr3 : pslverr0;
  assign s_prdata  = sel3 ? prdata3  : prdata0;
  assign s_addr    = sel3 ? addr3    : addr0;
  assign s_wdata   = sel3 ? wr_data3 : wr_data0;

  // Register blocks behind each bridge: reset to 0x1000_000i, written on wr_en.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        regs0[i] <= 32'h1000_0000 | 32'(i);
        regs3[i] <= 32'h1000_0000 | 32'(i);
      end
    end else begin
      if (wr_en0) regs0[addr0[4:2]] <= wr_data0;
      if (wr_en3) regs3[addr3[4:2]] <= wr_data3;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en0) begin
      wr_cnt0++;
      wr_t_prev = wr_t_last;
      wr_t_last = cyc;
    end
    if (rd_en0) rd_cnt0++;
    if (wr_en3) wr_cnt3++;
    if (rd_en3) rd_cnt3++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic use3, input logic wr, input logic [12:0] a, input logic [31:0] d);
    int  w0, r0, n;
    logic done;
    sel3 = use3;
    w0 = use3 ? wr_cnt3 : wr_cnt0;
    r0 = use3 ? rd_cnt3 : rd_cnt0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    n = 0; done = 1'b0; pre_nz = 1'b0;
    while (!done && n < 16) begin
      @(negedge clk);
      n++;
      if (s_pready) begin
        done = 1'b1;
        obs_prdata = s_prdata; obs_err = s_pslverr;
        obs_addr = s_addr; obs_wdata = s_wdata;
      end else if (s_prdata != 32'h0) begin
        pre_nz = 1'b1;
      end
    end
    check("xfer_done", 32'(done), 32'd1);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    obs_len = n + 1;
    obs_wr = (use3 ? wr_cnt3 : wr_cnt0) - w0;
    obs_rd = (use3 ? rd_cnt3 : rd_cnt0) - r0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    int w0;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_strobes0", {28'h0, pready0, pslverr0, wr_en0, rd_en0}, 32'h0);
    check("rst_prdata0", prdata0, 32'h0);
    check("rst_addr0", 32'(addr0), 32'h0);
    check("rst_wdata0", wr_data0, 32'h0);
    check("rst_strobes3", {28'h0, pready3, pslverr3, wr_en3, rd_en3}, 32'h0);
    #1 rst_n = 1'b1;

    xfer(1'b0, 1'b1, 13'h00C, 32'h0000_1234);
    check("w0_len", 32'(obs_len), 32'd2);
    check("w0_wr_en", 32'(obs_wr), 32'd1);
    check("w0_addr", 32'(obs_addr), 32'h00C);
    check("w0_wdata", obs_wdata, 32'h0000_1234);
    check("w0_slverr", 32'(obs_err), 32'h0);
    check("w0_rd_en", 32'(obs_rd), 32'd0);

    xfer(1'b0, 1'b1, 13'h014, 32'hA5A5_0001);
    xfer(1'b0, 1'b0, 13'h014, 32'h0);
    check("raw_prdata", obs_prdata, 32'hA5A5_0001);
    check("raw_rd_en", 32'(obs_rd), 32'd1);
    check("raw_wr_en", 32'(obs_wr), 32'd0);
    check("raw_slverr", 32'(obs_err), 32'h0);

    xfer(1'b1, 1'b0, 13'h000, 32'h0);
    check("ws3_len", 32'(obs_len), 32'd5);
    check("ws3_early_prdata", 32'(pre_nz), 32'h0);
    check("ws3_prdata", obs_prdata, 32'h1000_0000);
    check("ws3_rd_en", 32'(obs_rd), 32'd1);

    xfer(1'b0, 1'b1, 13'h020, 32'hDEAD_BEEF);
    check("err_w_slverr", 32'(obs_err), 32'h1);
    check("err_w_wr_en", 32'(obs_wr), 32'd0);
    check("err_w_prdata", obs_prdata, 32'h0);

    xfer(1'b0, 1'b0, 13'h00E, 32'h0);
    check("err_r_slverr", 32'(obs_err), 32'h1);
    check("err_r_rd_en", 32'(obs_rd), 32'd0);
    check("err_r_prdata", obs_prdata, 32'h0);

    // Abort a 3-wait-state write after one access cycle.
    w0 = wr_cnt3;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 13'h004; pwdata = 32'h0BAD_0BAD;
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk);
    check("abort_pready", 32'(pready3), 32'h0);
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_wr_en", 32'(wr_cnt3 - w0), 32'd0);
    xfer(1'b1, 1'b0, 13'h004, 32'h0);
    check("abort_after_len", 32'(obs_len), 32'd5);
    check("abort_after_data", obs_prdata, 32'h1000_0001);

    // Enable held with no setup phase.
    stray_hit = 1'b0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 13'h000;
    repeat (6) begin
      @(negedge clk);
      if (pready0 || pready3 || wr_en0 || wr_en3) stray_hit = 1'b1;
    end
    check("stray_pready", 32'(stray_hit), 32'h0);
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;

    // Reset asserted during the completing access cycle.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 13'h010; pwdata = 32'h0000_0055;
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk);
    check("rst_mid_pready_before", 32'(pready0), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_strobes0", {28'h0, pready0, pslverr0, wr_en0, rd_en0}, 32'h0);
    check("rst_mid_prdata0", prdata0, 32'h0);
    check("rst_mid_addr0", 32'(addr0), 32'h0);
    check("rst_mid_wdata0", wr_data0, 32'h0);
    check("rst_mid_addr3", 32'(addr3), 32'h0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    // Back-to-back writes on the zero-wait bridge.
    sel3 = 1'b0;
    w0 = wr_cnt0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 13'h004; pwdata = 32'h1111_1111;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1;
    penable = 1'b0; paddr = 13'h008; pwdata = 32'h2222_2222;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    check("b2b_wr_count", 32'(wr_cnt0 - w0), 32'd2);
    check("b2b_spacing", 32'(wr_t_last - wr_t_prev), 32'd2);
    xfer(1'b0, 1'b0, 13'h004, 32'h0);
    check("b2b_rd_a", obs_prdata, 32'h1111_1111);
    xfer(1'b0, 1'b0, 13'h008, 32'h0);
    check("b2b_rd_b", obs_prdata, 32'h2222_2222);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
